video_frame_checker: RTL and testbench

VIDEO_FRAME_CHECKER -- requirements
Module: video_frame_checker

---
 rtl/video_frame_checker_pkg.sv | 13 +
 rtl/video_frame_checker_skid_buf.sv | 79 +++++++
 rtl/video_frame_checker.sv | 123 ++++++++++++
 tb/tb_video_frame_checker.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_frame_checker_pkg.sv
// Shared types and constants for the video frame checker: FSM states and err_o bit positions.
package video_check_pkg;

  typedef enum logic [0:0] {
    ST_WAIT_SOF = 1'b0,
    ST_IN_FRAME = 1'b1
  } state_e;

  localparam int ERR_WIDTH  = 0;
  localparam int ERR_HEIGHT = 1;
  localparam int ERR_STRAY  = 2;

endpackage

// File: rtl/video_frame_checker_skid_buf.sv
// Two-entry AXI-Stream skid buffer carrying tuser/tlast alongside the data.
// Ready is taken from a register, so it has no combinational path from downstream.
module axis_skid_buf #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  input  logic                  s_tuser_i,
  input  logic                  s_tlast_i,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic                  m_tuser_o,
  output logic                  m_tlast_o
);

  localparam int PW = DATA_WIDTH + 2;

  logic [PW-1:0] slot0_q, slot0_d, slot1_q, slot1_d, in_w;
  logic [1:0]    cnt_q, cnt_d;
  logic          rdy_q;
  logic          push, pop;

  assign in_w = {s_tuser_i, s_tlast_i, s_tdata_i};
  assign push = s_tvalid_i && rdy_q;
  assign pop  = (cnt_q != 2'd0) && m_tready_i;

  // slot0 is always the head presented downstream; slot1 only fills when slot0 is stalled
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) slot0_d = in_w;
        else               slot1_d = in_w;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          slot0_d = slot1_q;
          slot1_d = in_w;
        end else begin
          slot0_d = in_w;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 2'd0;
      rdy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != 2'd2);
    end
  end

  always_ff @(posedge clk_i) begin
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

  assign s_tready_o = rdy_q;
  assign m_tvalid_o = (cnt_q != 2'd0);
  assign m_tuser_o  = slot0_q[PW-1];
  assign m_tlast_o  = slot0_q[PW-2];
  assign m_tdata_o  = slot0_q[DATA_WIDTH-1:0];

endmodule

// File: rtl/video_frame_checker.sv
// Pass-through video stream checker: forwards beats via a skid buffer and measures
// line width, frame height and frame count on accepted input beats, with sticky error flags.
module video_frame_checker
  import video_check_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int FRAME_WIDTH  = 1920,
  parameter int FRAME_HEIGHT = 1080,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  input  logic                  s_tuser_i,
  input  logic                  s_tlast_i,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic                  m_tuser_o,
  output logic                  m_tlast_o,
  input  logic                  clr_i,
  output logic [CNT_WIDTH-1:0]  width_o,
  output logic [CNT_WIDTH-1:0]  height_o,
  output logic [31:0]           frame_cnt_o,
  output logic [2:0]            err_o,
  output logic                  frame_done_o
);

  localparam logic [CNT_WIDTH-1:0] FW_C = CNT_WIDTH'(FRAME_WIDTH);
  localparam logic [CNT_WIDTH-1:0] FH_C = CNT_WIDTH'(FRAME_HEIGHT);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                 rdy_w;
  logic                 acc;
  state_e               state_q;
  logic [CNT_WIDTH-1:0] px_q, ln_q, width_q, height_q;
  logic [31:0]          frame_cnt_q;
  logic [2:0]           err_q, err_d, err_set;
  logic                 done_q;
  logic [CNT_WIDTH-1:0] px_base, ln_base, px_inc, ln_inc;
  logic                 stray, early_sof, line_end, frame_end;

  axis_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .s_tdata_i  (s_tdata_i),
    .s_tvalid_i (s_tvalid_i),
    .s_tready_o (rdy_w),
    .s_tuser_i  (s_tuser_i),
    .s_tlast_i  (s_tlast_i),
    .m_tdata_o  (m_tdata_o),
    .m_tvalid_o (m_tvalid_o),
    .m_tready_i (m_tready_i),
    .m_tuser_o  (m_tuser_o),
    .m_tlast_o  (m_tlast_o)
  );

  assign acc = s_tvalid_i && rdy_w;

  // A tuser beat restarts counting before its own tlast is considered, so SOF+EOL measures width 1
  always_comb begin
    px_base   = s_tuser_i ? '0 : px_q;
    ln_base   = s_tuser_i ? '0 : ln_q;
    px_inc    = sat_inc(px_base);
    ln_inc    = sat_inc(ln_base);
    stray     = acc && (state_q == ST_WAIT_SOF) && !s_tuser_i;
    early_sof = acc && (state_q == ST_IN_FRAME) && s_tuser_i;
    line_end  = acc && !stray && s_tlast_i;
    frame_end = line_end && (ln_inc == FH_C);
    err_set             = 3'b000;
    err_set[ERR_WIDTH]  = line_end && (px_inc != FW_C);
    err_set[ERR_HEIGHT] = early_sof;
    err_set[ERR_STRAY]  = stray;
    err_d = (clr_i ? 3'b000 : err_q) | err_set;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_WAIT_SOF;
      px_q        <= '0;
      ln_q        <= '0;
      width_q     <= '0;
      height_q    <= '0;
      frame_cnt_q <= '0;
      err_q       <= 3'b000;
      done_q      <= 1'b0;
    end else begin
      err_q  <= err_d;
      done_q <= frame_end;
      if (acc && !stray) begin
        if (line_end) begin
          width_q <= px_inc;
          px_q    <= '0;
          ln_q    <= frame_end ? '0 : ln_inc;
        end else begin
          px_q <= px_inc;
          ln_q <= ln_base;
        end
        if (frame_end) begin
          height_q    <= FH_C;
          frame_cnt_q <= frame_cnt_q + 32'd1;
          state_q     <= ST_WAIT_SOF;
        end else begin
          if (early_sof) height_q <= ln_q;
          state_q <= ST_IN_FRAME;
        end
      end
    end
  end

  assign s_tready_o   = rdy_w;
  assign width_o      = width_q;
  assign height_o     = height_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign err_o        = err_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_video_frame_checker.sv
// Randomized bench for video_frame_checker: beat scoreboard plus a frame-level measurement model.
module tb_video_frame_checker;

  localparam int DW = 16;
  localparam int FW = 8;
  localparam int FH = 4;
  localparam int CW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          user;
    logic          last;
  } beat_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [DW-1:0] s_tdata_i = '0;
  logic          s_tvalid_i = 1'b0;
  logic          s_tready_o;
  logic          s_tuser_i = 1'b0;
  logic          s_tlast_i = 1'b0;
  logic [DW-1:0] m_tdata_o;
  logic          m_tvalid_o;
  logic          m_tready_i = 1'b1;
  logic          m_tuser_o;
  logic          m_tlast_o;
  logic          clr_i = 1'b0;
  logic [CW-1:0] width_o;
  logic [CW-1:0] height_o;
  logic [31:0]   frame_cnt_o;
  logic [2:0]    err_o;
  logic          frame_done_o;

  video_frame_checker #(
    .DATA_WIDTH(DW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_tdata_i(s_tdata_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
    .s_tuser_i(s_tuser_i), .s_tlast_i(s_tlast_i),
    .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
    .m_tuser_o(m_tuser_o), .m_tlast_o(m_tlast_o),
    .clr_i(clr_i), .width_o(width_o), .height_o(height_o),
    .frame_cnt_o(frame_cnt_o), .err_o(err_o), .frame_done_o(frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  beat_t stim_q[$];
  beat_t sb_q[$];

  // Frame-level reference: counts beats per line and lines per frame
  bit          in_frame;
  int          px_seen, lines_seen;
  logic [31:0] e_width, e_height, e_fcnt;
  logic [2:0]  e_err;
  bit          e_done;
  bit          mon_en = 1'b0;
  bit          acc_last = 1'b0;
  int          post = 0;
  int          done_cnt = 0;

  task automatic model_reset();
    in_frame = 0; px_seen = 0; lines_seen = 0;
    e_width = 0; e_height = 0; e_fcnt = 0; e_err = 3'b000; e_done = 0;
    sb_q.delete();
  endtask

  task automatic model_beat(input beat_t b, output logic [2:0] set, output bit done);
    set = 3'b000;
    done = 0;
    if (!in_frame && !b.user) begin
      set[2] = 1'b1;
    end else begin
      if (b.user) begin
        if (in_frame) begin
          set[1] = 1'b1;
          e_height = 32'(lines_seen);
        end
        in_frame = 1; px_seen = 0; lines_seen = 0;
      end
      px_seen++;
      if (b.last) begin
        e_width = 32'(px_seen);
        if (px_seen != FW) set[0] = 1'b1;
        px_seen = 0;
        lines_seen++;
        if (lines_seen == FH) begin
          e_height = FH;
          e_fcnt = e_fcnt + 1;
          done = 1;
          in_frame = 0;
          lines_seen = 0;
        end
      end
    end
  endtask

  always @(negedge clk_i) begin
    if (mon_en) begin
      if (rst_i) begin
        check_val("rst_ready", 32'(s_tready_o), 0);
        check_val("rst_mvalid", 32'(m_tvalid_o), 0);
        check_val("rst_width", 32'(width_o), 0);
        check_val("rst_height", 32'(height_o), 0);
        check_val("rst_fcnt", frame_cnt_o, 0);
        check_val("rst_err", 32'(err_o), 0);
        check_val("rst_done", 32'(frame_done_o), 0);
        model_reset();
        post = 0;
        acc_last = 0;
      end else begin
        logic [2:0] set;
        bit         done;
        beat_t      b;
        post++;
        check_val("s_tready", 32'(s_tready_o), (post == 1) ? 32'd0 : 32'(sb_q.size() < 2));
        check_val("m_tvalid", 32'(m_tvalid_o), 32'(sb_q.size() > 0));
        if (m_tvalid_o && sb_q.size() > 0)
          check_val("beat", 32'({m_tuser_o, m_tlast_o, m_tdata_o}),
                    32'({sb_q[0].user, sb_q[0].last, sb_q[0].data}));
        check_val("width", 32'(width_o), e_width);
        check_val("height", 32'(height_o), e_height);
        check_val("fcnt", frame_cnt_o, e_fcnt);
        check_val("err", 32'(err_o), 32'(e_err));
        check_val("done", 32'(frame_done_o), 32'(e_done));
        if (frame_done_o) done_cnt++;
        if (m_tvalid_o && m_tready_i && sb_q.size() > 0) void'(sb_q.pop_front());
        acc_last = s_tvalid_i && s_tready_o;
        set = 3'b000;
        done = 0;
        if (acc_last) begin
          b.data = s_tdata_i; b.user = s_tuser_i; b.last = s_tlast_i;
          sb_q.push_back(b);
          model_beat(b, set, done);
        end
        e_err  = (clr_i ? 3'b000 : e_err) | set;
        e_done = done;
      end
    end
  end

  task automatic gen_line(input int n, input bit sof);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = DW'($urandom);
      b.user = sof && (i == 0);
      b.last = (i == n - 1);
      stim_q.push_back(b);
    end
  endtask

  task automatic gen_frame(input int short_line, input int short_len);
    for (int l = 0; l < FH; l++) gen_line((l == short_line) ? short_len : FW, l == 0);
  endtask

  task automatic drive(input int vpct, input int rpct, input int limit);
    int    cyc = 0;
    int    sent = 0;
    bit    have = 0;
    beat_t b = '0;
    while ((have || (stim_q.size() > 0 && sent < limit)) && cyc < 4000) begin
      if (!have && stim_q.size() > 0 && sent < limit && int'($urandom_range(99)) < vpct) begin
        b = stim_q.pop_front();
        have = 1;
      end
      s_tvalid_i = have;
      s_tdata_i  = have ? b.data : '0;
      s_tuser_i  = have && b.user;
      s_tlast_i  = have && b.last;
      m_tready_i = int'($urandom_range(99)) < rpct;
      @(posedge clk_i); #1;
      if (have && acc_last) begin
        have = 0;
        sent++;
      end
      cyc++;
    end
    if (cyc >= 4000) check_val("drive_timeout", 32'(cyc), 0);
    s_tvalid_i = 0; s_tuser_i = 0; s_tlast_i = 0; s_tdata_i = '0;
    m_tready_i = 1;
    repeat (5) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    s_tvalid_i = 0; s_tuser_i = 0; s_tlast_i = 0; m_tready_i = 1; clr_i = 0;
    rst_i = 1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 0;
    stim_q.delete();
    done_cnt = 0;
    @(posedge clk_i); #1;
  endtask

  task automatic pulse_clr();
    clr_i = 1;
    @(posedge clk_i); #1;
    clr_i = 0;
  endtask

  initial begin
    #2 rst_i = 1;
    #1 mon_en = 1;
    @(posedge clk_i); #1;
    do_reset();

    // two clean frames, downstream always ready
    gen_frame(-1, FW);
    gen_frame(-1, FW);
    drive(100, 100, 1000000);
    check_val("clean_width", 32'(width_o), FW);
    check_val("clean_height", 32'(height_o), FH);
    check_val("clean_fcnt", frame_cnt_o, 2);
    check_val("clean_err", 32'(err_o), 0);
    check_val("clean_done_pulses", 32'(done_cnt), 2);

    // short second line
    do_reset();
    gen_frame(1, 6);
    drive(100, 100, FW + 6);
    check_val("short_width", 32'(width_o), 6);
    check_val("short_err", 32'(err_o), 3'b001);
    drive(100, 100, 1000000);
    check_val("short_fcnt", frame_cnt_o, 1);
    check_val("short_err_sticky", 32'(err_o), 3'b001);

    // early SOF after two complete lines
    do_reset();
    gen_line(FW, 1);
    gen_line(FW, 0);
    gen_frame(-1, FW);
    drive(100, 100, 2 * FW + 1);
    check_val("esof_err", 32'(err_o), 3'b010);
    check_val("esof_height", 32'(height_o), 2);
    check_val("esof_fcnt", frame_cnt_o, 0);
    drive(100, 100, 1000000);
    check_val("esof_next_fcnt", frame_cnt_o, 1);
    check_val("esof_next_height", 32'(height_o), FH);

    // stray beats, clear, then a clean frame
    do_reset();
    gen_line(3, 0);
    drive(100, 100, 1000000);
    check_val("stray_err", 32'(err_o), 3'b100);
    pulse_clr();
    check_val("clr_err", 32'(err_o), 0);
    gen_frame(-1, FW);
    drive(100, 100, 1000000);
    check_val("stray_fcnt", frame_cnt_o, 1);

    // random backpressure and gaps over three frames
    do_reset();
    repeat (3) gen_frame(-1, FW);
    drive(70, 50, 1000000);
    check_val("rand_fcnt", frame_cnt_o, 3);
    check_val("rand_err", 32'(err_o), 0);
    check_val("rand_done_pulses", 32'(done_cnt), 3);
    check_val("rand_drained", 32'(sb_q.size()), 0);

    // reset in the middle of line 3, then a clean frame
    do_reset();
    gen_frame(-1, FW);
    drive(100, 100, 2 * FW + 3);
    do_reset();
    gen_frame(-1, FW);
    drive(100, 100, 1000000);
    check_val("midrst_fcnt", frame_cnt_o, 1);
    check_val("midrst_err", 32'(err_o), 0);

    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
